// File: rtl/decim_timing_ctrl.sv
// Timing controller for the DSM decimation filter. Everything runs on the master
// clk. Clock-enable strobes replace divided clocks, and one shared comb
// subtractor is time-multiplexed across the comb stages. The decimated sample is
// presented through a valid/ready handshake.
// Optional build macro: OVR_COUNT_EN adds the 8-bit saturating ovrCount output.
module decim_timing_ctrl #(
  parameter int MAX_LOG2_RATIO = 6,
  parameter int COMB_STAGES    = 3,
  parameter int RST_LOG2_RATIO = 6
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       enable,
  input  logic [2:0] cfgLog2Ratio,
  input  logic       cfgLoad,
  output logic       stbFast,
  output logic       stbSlow,
  output logic       combEn,
  output logic [1:0] combSel,
  output logic       outValid,
  input  logic       outReady,
  output logic       overrun,
  input  logic       ovrClr
`ifdef OVR_COUNT_EN
  ,
  output logic [7:0] ovrCount
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, COMB = 2'd1, HOLD = 2'd2} ctrlState_t;

  localparam int             CW       = MAX_LOG2_RATIO;
  localparam logic [2:0]     MIN_LOG2 = 3'd3;
  localparam logic [2:0]     MAX_LOG2 = 3'(MAX_LOG2_RATIO);
  localparam logic [2:0]     RST_LOG2 = 3'(RST_LOG2_RATIO);
  localparam logic [1:0]     LAST_SEL = 2'(COMB_STAGES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  // Keep a requested exponent inside the supported 3..MAX range.
  function automatic logic [2:0] clampLog2(input logic [2:0] v);
    logic [2:0] r;
    if (v < MIN_LOG2) begin
      r = MIN_LOG2;
    end else if (v > MAX_LOG2) begin
      r = MAX_LOG2;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Mask with the nBits least significant bits set.
  function automatic logic [CW-1:0] lowMask(input logic [2:0] nBits);
    logic [CW-1:0] m;
    for (int i = 0; i < CW; i++) begin
      m[i] = (i < int'(nBits));
    end
    return m;
  endfunction

  logic [CW-1:0] cnt_r;
  logic [2:0]    log2Ratio_r;
  logic [2:0]    pendLog2_r;
  logic          pendValid_r;
  ctrlState_t    state_r;
  ctrlState_t    stateNext_s;
  logic [1:0]    combSel_r;
  logic [1:0]    combSelNext_s;
  logic          overrun_r;
  logic          drop_s;
  logic [CW-1:0] ratioMask_s;
  logic [CW-1:0] fastMask_s;
  logic          wrap_s;
  logic          stbSlow_s;
  logic          stbFast_s;
  logic [2:0]    cfgClamped_s;

  // R-1 is all ones in the low k bits. The fast strobe fires when the low k-3
  // bits are all ones, so it pulses 8 times per period and every cycle for k=3.
  assign ratioMask_s  = lowMask(log2Ratio_r);
  assign fastMask_s   = lowMask(log2Ratio_r - 3'd3);
  assign wrap_s       = (cnt_r == ratioMask_s);
  assign stbSlow_s    = enable & wrap_s;
  assign stbFast_s    = enable & ((cnt_r & fastMask_s) == fastMask_s);
  assign cfgClamped_s = clampLog2(cfgLog2Ratio);

  // Counter and ratio. A new ratio takes effect only at the period wrap, unless
  // the counter is stopped, in which case it applies at once and restarts cnt.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      cnt_r       <= '0;
      log2Ratio_r <= RST_LOG2;
      pendLog2_r  <= 3'd0;
      pendValid_r <= 1'b0;
    end else if (!enable) begin
      if (cfgLoad) begin
        log2Ratio_r <= cfgClamped_s;
        cnt_r       <= '0;
        pendValid_r <= 1'b0;
      end
    end else if (wrap_s) begin
      cnt_r       <= '0;
      pendValid_r <= 1'b0;
      if (cfgLoad) begin
        log2Ratio_r <= cfgClamped_s;
      end else if (pendValid_r) begin
        log2Ratio_r <= pendLog2_r;
      end
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
      if (cfgLoad) begin
        pendLog2_r  <= cfgClamped_s;
        pendValid_r <= 1'b1;
      end
    end
  end

  // Sequencer state and comb stage index.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_r   <= IDLE;
      combSel_r <= 2'd0;
    end else begin
      state_r   <= stateNext_s;
      combSel_r <= combSelNext_s;
    end
  end

  // Next-state logic. A slow strobe that cannot start a sequence is a drop. When
  // enable is low, the machine freezes, but a HOLD handshake still completes.
  always_comb begin
    stateNext_s   = state_r;
    combSelNext_s = combSel_r;
    drop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (stbSlow_s) begin
          stateNext_s   = COMB;
          combSelNext_s = 2'd0;
        end else begin
          stateNext_s = IDLE;
        end
      end
      COMB: begin
        drop_s = stbSlow_s;
        if (!enable) begin
          stateNext_s = COMB;
        end else if (combSel_r == LAST_SEL) begin
          stateNext_s   = HOLD;
          combSelNext_s = 2'd0;
        end else begin
          stateNext_s   = COMB;
          combSelNext_s = combSel_r + 2'd1;
        end
      end
      HOLD: begin
        if (outReady) begin
          if (stbSlow_s) begin
            stateNext_s   = COMB;
            combSelNext_s = 2'd0;
          end else begin
            stateNext_s = IDLE;
          end
        end else begin
          drop_s = stbSlow_s;
        end
      end
      default: begin
        stateNext_s   = IDLE;
        combSelNext_s = 2'd0;
      end
    endcase
  end

  // Sticky overrun flag. A drop in the same cycle as a clear leaves it set.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (ovrClr) begin
      overrun_r <= 1'b0;
    end
  end

`ifdef OVR_COUNT_EN
  logic [7:0] ovrCount_r;

  // Saturating count of dropped events. A clear that coincides with a drop
  // counts that drop.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      ovrCount_r <= 8'd0;
    end else if (drop_s) begin
      if (ovrClr) begin
        ovrCount_r <= 8'd1;
      end else if (ovrCount_r != 8'hFF) begin
        ovrCount_r <= ovrCount_r + 8'd1;
      end
    end else if (ovrClr) begin
      ovrCount_r <= 8'd0;
    end
  end

  assign ovrCount = ovrCount_r;
`endif

  assign stbFast  = stbFast_s;
  assign stbSlow  = stbSlow_s;
  assign combEn   = (state_r == COMB) & enable;
  assign combSel  = combSel_r;
  assign outValid = (state_r == HOLD);
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_decim_timing_ctrl.sv
// Self-checking bench for decim_timing_ctrl with the default parameters
// (MAX_LOG2_RATIO=6, COMB_STAGES=3, RST_LOG2_RATIO=6).
`timescale 1ns/1ps
module tb_decim_timing_ctrl;
  localparam int NSTAGE = 3;

  logic       clk = 1'b0;
  logic       rstN;
  logic       enable;
  logic [2:0] cfgLog2Ratio;
  logic       cfgLoad;
  logic       stbFast;
  logic       stbSlow;
  logic       combEn;
  logic [1:0] combSel;
  logic       outValid;
  logic       outReady;
  logic       overrun;
  logic       ovrClr;
`ifdef OVR_COUNT_EN
  logic [7:0] ovrCount;
`endif

  decim_timing_ctrl dut (
    .clk(clk), .rstN(rstN), .enable(enable), .cfgLog2Ratio(cfgLog2Ratio),
    .cfgLoad(cfgLoad), .stbFast(stbFast), .stbSlow(stbSlow), .combEn(combEn),
    .combSel(combSel), .outValid(outValid), .outReady(outReady),
    .overrun(overrun), .ovrClr(ovrClr)
`ifdef OVR_COUNT_EN
    , .ovrCount(ovrCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] cfg; int period; int fastPeriod; } cfgVec_t;
  typedef struct { int cyc; logic [1:0] sel; } combExp_t;

  cfgVec_t  tbl[7];
  combExp_t sbq[$];
  combExp_t monE;
  int       cyc    = 0;
  int       nChecks = 0;
  int       nPass   = 0;
  int       ovDue   = -1;
  bit       monOn   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s at cycle %0d: actual=%0b required=%0b", name, cyc, act, exp);
  endtask

  task automatic chkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
  endtask

  task automatic chkInt(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Expect combEn in the NSTAGE cycles after a slow strobe at cycle t.
  task automatic pushSeq(input int t);
    for (int s = 0; s < NSTAGE; s++) sbq.push_back('{t + 1 + s, 2'(s)});
  endtask

  // Free-running check with outReady high: strobes, outValid due 4 cycles after stbSlow.
  task automatic stdCheck(input logic fExp, input logic sExp);
    chkBit("stbFast", stbFast, fExp);
    chkBit("stbSlow", stbSlow, sExp);
    chkBit("outValid", outValid, cyc == ovDue);
    chkBit("overrun", overrun, 1'b0);
    if (sExp) begin
      pushSeq(cyc);
      ovDue = cyc + NSTAGE + 1;
    end
  endtask

  // Scoreboard monitor: each combEn cycle must match the next expected (cycle, combSel).
  always @(negedge clk) begin
    if (monOn) begin
      if (combEn) begin
        if (sbq.size() == 0) begin
          nChecks++;
          $display("FAIL combEnSpurious at cycle %0d: actual combEn=1 required=0", cyc);
        end else begin
          monE = sbq.pop_front();
          chkInt("combEnCycle", cyc, monE.cyc);
          chkVal("combSel", {6'd0, combSel}, {6'd0, monE.sel});
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        nChecks++;
        $display("FAIL combEnMissing at cycle %0d: actual combEn=0 required=1", cyc);
        monE = sbq.pop_front();
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'd7, 64, 8};
    tbl[1] = '{3'd0,  8, 1};
    tbl[2] = '{3'd2,  8, 1};
    tbl[3] = '{3'd3,  8, 1};
    tbl[4] = '{3'd5, 32, 4};
    tbl[5] = '{3'd4, 16, 2};
    tbl[6] = '{3'd6, 64, 8};

    rstN = 1'b0; enable = 1'b1; cfgLog2Ratio = 3'd0; cfgLoad = 1'b0;
    outReady = 1'b1; ovrClr = 1'b0;

    // Reset defaults
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkBit("rst_stbFast", stbFast, 1'b0);
    chkBit("rst_stbSlow", stbSlow, 1'b0);
    chkBit("rst_combEn", combEn, 1'b0);
    chkVal("rst_combSel", {6'd0, combSel}, 8'd0);
    chkBit("rst_outValid", outValid, 1'b0);
    chkBit("rst_overrun", overrun, 1'b0);
`ifdef OVR_COUNT_EN
    chkVal("rst_ovrCount", ovrCount, 8'd0);
`endif
    nextCycle();
    rstN  = 1'b1;
    monOn = 1'b1;

    // Default R=64, then ratio 4 loaded at cnt=10, then 7 (clamps to 6)
    for (int i = 0; i < 280; i++) begin
      int e;
      int r;
      cfgLoad      = (i == 138) || (i == 200);
      cfgLog2Ratio = (i == 200) ? 3'd7 : 3'd4;
      if (i < 192) begin
        e = i; r = 64;
      end else if (i < 208) begin
        e = i - 192; r = 16;
      end else begin
        e = i - 208; r = 64;
      end
      @(negedge clk);
      stdCheck((e % (r / 8)) == (r / 8 - 1), (e % r) == (r - 1));
      nextCycle();
    end
    cfgLoad = 1'b0;

    // Table: immediate load while disabled, including clamping at both ends
    foreach (tbl[t]) begin
      enable = 1'b0; cfgLoad = 1'b1; cfgLog2Ratio = tbl[t].cfg;
      @(negedge clk);
      chkBit("dis_stbFast", stbFast, 1'b0);
      chkBit("dis_stbSlow", stbSlow, 1'b0);
      chkBit("dis_combEn", combEn, 1'b0);
      nextCycle();
      enable = 1'b1; cfgLoad = 1'b0;
      for (int i = 0; i < 2 * tbl[t].period + 6; i++) begin
        @(negedge clk);
        stdCheck((i % tbl[t].fastPeriod) == (tbl[t].fastPeriod - 1),
                 (i % tbl[t].period) == (tbl[t].period - 1));
        nextCycle();
      end
    end

    // Backpressure, overrun clear, coincident handshake, drop with clear, reset in HOLD (R=16)
    enable = 1'b0; cfgLoad = 1'b1; cfgLog2Ratio = 3'd4;
    nextCycle();
    enable = 1'b1; cfgLoad = 1'b0;
    for (int i = 0; i < 116; i++) begin
      outReady = (i == 50) || (i >= 79 && i <= 83);
      ovrClr   = (i == 50) || (i == 111);
      rstN     = (i != 115);
      @(negedge clk);
      chkBit("bp_stbFast", stbFast, (i % 2) == 1);
      chkBit("bp_stbSlow", stbSlow, (i % 16) == 15);
      chkBit("bp_outValid", outValid,
             (i >= 19 && i <= 50) || (i >= 67 && i <= 79) || (i == 83) || (i >= 99));
      chkBit("bp_overrun", overrun, (i >= 32 && i <= 50) || (i >= 112));
`ifdef OVR_COUNT_EN
      chkVal("bp_ovrCount", ovrCount,
             (i < 32) ? 8'd0 : (i < 48) ? 8'd1 : (i < 51) ? 8'd2 : (i < 112) ? 8'd0 : 8'd1);
`endif
      if (i == 15 || i == 63 || i == 79 || i == 95) pushSeq(cyc);
      nextCycle();
    end
    rstN = 1'b1; outReady = 1'b1; ovrClr = 1'b0;

    // After reset in HOLD; then enable low for 5 cycles during COMB (R=64 again)
    for (int j = 0; j < 137; j++) begin
      int e;
      enable = !(j >= 65 && j <= 69);
      @(negedge clk);
      if (j == 0) begin
        chkBit("rstHold_outValid", outValid, 1'b0);
        chkBit("rstHold_overrun", overrun, 1'b0);
        chkVal("rstHold_combSel", {6'd0, combSel}, 8'd0);
`ifdef OVR_COUNT_EN
        chkVal("rstHold_ovrCount", ovrCount, 8'd0);
`endif
      end
      e = (j < 65) ? j : j - 5;
      chkBit("en_stbFast", stbFast, enable && ((e % 8) == 7));
      chkBit("en_stbSlow", stbSlow, enable && ((e % 64) == 63));
      chkBit("en_outValid", outValid, (j == 72) || (j == 136));
      chkBit("en_overrun", overrun, 1'b0);
      if (j >= 65 && j <= 69) begin
        chkBit("frz_combEn", combEn, 1'b0);
        chkVal("frz_combSel", {6'd0, combSel}, 8'd1);
      end
      if (j == 63) begin
        sbq.push_back('{cyc + 1, 2'd0});
        sbq.push_back('{cyc + 7, 2'd1});
        sbq.push_back('{cyc + 8, 2'd2});
      end
      if (j == 132) pushSeq(cyc);
      nextCycle();
    end

    chkInt("scoreboardEmpty", sbq.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
